// File: rtl/card_click_decoder_pkg.sv
// card_click_decoder_pkg
//   Shared definitions for the card click decoder: the board memory card state
//   codes, the default grid geometry, and the decoder FSM state type.
//   This package has no ports.
package card_click_decoder_pkg;

  localparam logic [1:0] CARD_EMPTY       = 2'b00;
  localparam logic [1:0] CARD_COVERED     = 2'b01;
  localparam logic [1:0] CARD_DEACTIVATED = 2'b10;
  localparam logic [1:0] CARD_DISCOVERED  = 2'b11;

  localparam int GRID_X0_DEF = 64;
  localparam int GRID_Y0_DEF = 60;
  localparam int CARD_W_DEF  = 128;
  localparam int CARD_H_DEF  = 140;
  localparam int GAP_DEF     = 32;
  localparam int COLS_DEF    = 4;
  localparam int GRID_ROWS   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_HIT    = 3'd2,
    ST_LOOKUP = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/card_click_decoder_hit_test.sv
// card_click_decoder_hit_test
//   Card hit test.
//   Maps a latched pixel position onto the card grid.
//   It reports whether the position lies on a card and, if so, that card's
//   address (row*COLS + col).
//   Ports:
//     i_x, i_y   in   12  latched mouse position
//     o_hit      out  1   position lies on a card (gaps and outside are misses)
//     o_address  out  4   card address, valid when o_hit
module card_click_decoder_hit_test
  import card_click_decoder_pkg::*;
#(
  parameter int GRID_X0 = GRID_X0_DEF,
  parameter int GRID_Y0 = GRID_Y0_DEF,
  parameter int CARD_W  = CARD_W_DEF,
  parameter int CARD_H  = CARD_H_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int COLS    = COLS_DEF
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_hit,
  output logic [3:0]  o_address
);

  localparam int CW = $clog2(COLS);

  logic [COLS-1:0]      w_col_hit;
  logic [GRID_ROWS-1:0] w_row_hit;
  logic [CW-1:0]        w_col_idx;
  logic [1:0]           w_row_idx;

  // Inclusive pixel windows; the pixel at start+W belongs to the gap.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [11:0] LO = 12'(GRID_X0 + c * (CARD_W + GAP));
    localparam logic [11:0] HI = 12'(GRID_X0 + c * (CARD_W + GAP) + CARD_W - 1);
    assign w_col_hit[c] = (i_x >= LO) && (i_x <= HI);
  end

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    localparam logic [11:0] LO = 12'(GRID_Y0 + r * (CARD_H + GAP));
    localparam logic [11:0] HI = 12'(GRID_Y0 + r * (CARD_H + GAP) + CARD_H - 1);
    assign w_row_hit[r] = (i_y >= LO) && (i_y <= HI);
  end

  // Windows never overlap, so at most one bit of each vector is set.
  always_comb begin
    w_col_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_col_hit[c]) w_col_idx = CW'(c);
    end
    w_row_idx = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (w_row_hit[r]) w_row_idx = 2'(r);
    end
  end

  assign o_hit     = (|w_col_hit) && (|w_row_hit);
  assign o_address = 4'(32'(w_row_idx) * COLS + 32'(w_col_idx));

endmodule

// File: rtl/card_click_decoder.sv
// card_click_decoder
//   Turns a left click into a validated card selection for the game FSM.
//   While i_wait_for_click_en is high, a synchronised press edge latches the
//   mouse position. The position is hit-tested against the grid, and the card
//   entry is read from board memory. A one-cycle o_card_pressed pulse is then
//   issued, but only for a covered card.
//   Ports:
//     clk, rst                 in   1   clock, synchronous active-high reset
//     i_wait_for_click_en      in   1   game FSM waiting for a card click
//     i_mouse_left             in   1   raw left button (asynchronous)
//     i_xpos, i_ypos           in   12  mouse position
//     i_card_state_rd          in   2   board memory state (1-cycle sync read)
//     i_card_color_rd          in   12  board memory colour
//     o_card_rd_address        out  4   board memory read address
//     o_card_pressed           out  1   one-cycle pulse on accepted card
//     o_card_clicked_address   out  4   last accepted card address
//     o_card_clicked_color     out  12  last accepted card colour
//
//   state  | meaning
//   IDLE   | not enabled, or waiting for the button to be released
//   ARMED  | waiting for a press edge
//   HIT    | position latched, hit test evaluated
//   LOOKUP | read address presented to board memory
//   CHECK  | memory data valid, accept if covered
//   DONE   | card reported, wait for enable to drop
module card_click_decoder
  import card_click_decoder_pkg::*;
#(
  parameter int GRID_X0 = GRID_X0_DEF,
  parameter int GRID_Y0 = GRID_Y0_DEF,
  parameter int CARD_W  = CARD_W_DEF,
  parameter int CARD_H  = CARD_H_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int COLS    = COLS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wait_for_click_en,
  input  logic        i_mouse_left,
  input  logic [11:0] i_xpos,
  input  logic [11:0] i_ypos,
  input  logic [1:0]  i_card_state_rd,
  input  logic [11:0] i_card_color_rd,
  output logic [3:0]  o_card_rd_address,
  output logic        o_card_pressed,
  output logic [3:0]  o_card_clicked_address,
  output logic [11:0] o_card_clicked_color
);

  logic        r_sync1, r_sync2, r_btn_prev;
  logic        w_press;
  logic [11:0] r_x, r_y;
  state_t      r_state, w_state_next;
  logic        w_hit;
  logic [3:0]  w_hit_address;
  logic        w_latch_xy, w_load_addr, w_accept;
  logic [3:0]  r_rd_address, r_clicked_address;
  logic [11:0] r_clicked_color;
  logic        r_pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_sync1    <= i_mouse_left;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_btn_prev;

  card_click_decoder_hit_test #(
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0),
    .CARD_W  (CARD_W),
    .CARD_H  (CARD_H),
    .GAP     (GAP),
    .COLS    (COLS)
  ) u_hit_test (
    .i_x       (r_x),
    .i_y       (r_y),
    .o_hit     (w_hit),
    .o_address (w_hit_address)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_wait_for_click_en && !r_sync2) w_state_next = ST_ARMED;
      ST_ARMED:  if (w_press) w_state_next = ST_HIT;
      ST_HIT:    w_state_next = w_hit ? ST_LOOKUP : ST_ARMED;
      ST_LOOKUP: w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = (i_card_state_rd == CARD_COVERED) ? ST_DONE : ST_ARMED;
      ST_DONE:   w_state_next = ST_DONE;
      default:   w_state_next = ST_IDLE;
    endcase
    // Dropping the enable aborts from anywhere, ahead of any acceptance.
    if (r_state != ST_IDLE && !i_wait_for_click_en) w_state_next = ST_IDLE;
  end

  always_comb begin
    w_latch_xy  = 1'b0;
    w_load_addr = 1'b0;
    w_accept    = 1'b0;
    if (i_wait_for_click_en) begin
      w_latch_xy  = (r_state == ST_ARMED) && w_press;
      w_load_addr = (r_state == ST_HIT) && w_hit;
      w_accept    = (r_state == ST_CHECK) && (i_card_state_rd == CARD_COVERED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x               <= '0;
      r_y               <= '0;
      r_rd_address      <= '0;
      r_clicked_address <= '0;
      r_clicked_color   <= '0;
      r_pressed         <= 1'b0;
    end else begin
      if (w_latch_xy) begin
        r_x <= i_xpos;
        r_y <= i_ypos;
      end
      if (w_load_addr) r_rd_address <= w_hit_address;
      if (w_accept) begin
        r_clicked_address <= r_rd_address;
        r_clicked_color   <= i_card_color_rd;
      end
      r_pressed <= w_accept;
    end
  end

  assign o_card_rd_address      = r_rd_address;
  assign o_card_pressed         = r_pressed;
  assign o_card_clicked_address = r_clicked_address;
  assign o_card_clicked_color   = r_clicked_color;

endmodule

// File: tb/tb_card_click_decoder.sv
// tb_card_click_decoder
//   Directed test of card_click_decoder: a table of single clicks
//   (position, memory contents, expected result), plus hand sequences for
//   the gap, abort, held-button and reset-in-CHECK cases.
module tb_card_click_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wait_for_click_en;
  logic        mouse_left;
  logic [11:0] xpos, ypos;
  logic [1:0]  card_state_rd;
  logic [11:0] card_color_rd;
  logic [3:0]  card_rd_address;
  logic        card_pressed;
  logic [3:0]  card_clicked_address;
  logic [11:0] card_clicked_color;

  logic [1:0]  mem_state [12];
  logic [11:0] mem_color [12];

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_addr  = '0;
  logic [11:0] exp_color = '0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  st;
    logic [11:0] base;
    int          exp_n;
    logic [3:0]  e_addr;
    logic [11:0] e_color;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  card_click_decoder dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_wait_for_click_en    (wait_for_click_en),
    .i_mouse_left           (mouse_left),
    .i_xpos                 (xpos),
    .i_ypos                 (ypos),
    .i_card_state_rd        (card_state_rd),
    .i_card_color_rd        (card_color_rd),
    .o_card_rd_address      (card_rd_address),
    .o_card_pressed         (card_pressed),
    .o_card_clicked_address (card_clicked_address),
    .o_card_clicked_color   (card_clicked_color)
  );

  // Board memory: one-cycle synchronous read.
  always @(posedge clk) begin
    card_state_rd <= mem_state[card_rd_address];
    card_color_rd <= mem_color[card_rd_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [1:0] st, input logic [11:0] base);
    for (int i = 0; i < 12; i++) begin
      mem_state[i] = st;
      mem_color[i] = base + 12'(i);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Press at a negedge, then count pulses over 10 cycles and note the first one.
  task automatic press_watch(input logic [11:0] x, input logic [11:0] y,
                             output int npulse, output int first_k);
    npulse  = 0;
    first_k = 0;
    @(negedge clk);
    xpos = x;
    ypos = y;
    mouse_left = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (card_pressed) begin
        npulse++;
        if (first_k == 0) first_k = k;
      end
    end
  endtask

  task automatic release_btn();
    mouse_left = 1'b0;
    wait_neg(4);
  endtask

  task automatic rearm();
    wait_for_click_en = 1'b0;
    wait_neg(2);
    wait_for_click_en = 1'b1;
    wait_neg(3);
  endtask

  task automatic watch_quiet(input int n, output int npulse);
    npulse = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (card_pressed) npulse++;
    end
  endtask

  initial begin
    int np, fk;
    rst = 1'b1;
    wait_for_click_en = 1'b0;
    mouse_left = 1'b0;
    xpos = '0;
    ypos = '0;
    fill(2'b00, 12'h000);
    wait_neg(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pressed", 32'(card_pressed), 32'd0);
    chk("reset_addr",    32'(card_clicked_address), 32'd0);
    chk("reset_color",   32'(card_clicked_color), 32'd0);
    chk("reset_rd_addr", 32'(card_rd_address), 32'd0);

    vecs.push_back('{12'd100,  12'd100,  2'b01, 12'hF00, 1, 4'd0,  12'hF00});
    vecs.push_back('{12'd200,  12'd100,  2'b01, 12'h111, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd600,  12'd500,  2'b01, 12'h0A0, 1, 4'd11, 12'h0AB});
    vecs.push_back('{12'd250,  12'd250,  2'b11, 12'h700, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd250,  12'd250,  2'b10, 12'h700, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd250,  12'd250,  2'b00, 12'h700, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd191,  12'd199,  2'b01, 12'h123, 1, 4'd0,  12'h123});
    vecs.push_back('{12'd192,  12'd100,  2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd64,   12'd60,   2'b01, 12'h200, 1, 4'd0,  12'h200});
    vecs.push_back('{12'd63,   12'd100,  2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd100,  12'd59,   2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd100,  12'd200,  2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd671,  12'd543,  2'b01, 12'h300, 1, 4'd11, 12'h30B});
    vecs.push_back('{12'd672,  12'd500,  2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd600,  12'd544,  2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd224,  12'd232,  2'b01, 12'h010, 1, 4'd5,  12'h015});
    vecs.push_back('{12'd351,  12'd371,  2'b01, 12'h020, 1, 4'd5,  12'h025});
    vecs.push_back('{12'd384,  12'd404,  2'b01, 12'h400, 1, 4'd10, 12'h40A});
    vecs.push_back('{12'd544,  12'd60,   2'b01, 12'h500, 1, 4'd3,  12'h503});
    vecs.push_back('{12'd0,    12'd0,    2'b01, 12'h900, 0, 4'd0,  12'h000});
    vecs.push_back('{12'd4095, 12'd4095, 2'b01, 12'h900, 0, 4'd0,  12'h000});

    rearm();
    for (int i = 0; i < vecs.size(); i++) begin
      fill(vecs[i].st, vecs[i].base);
      press_watch(vecs[i].x, vecs[i].y, np, fk);
      if (vecs[i].exp_n == 1) begin
        exp_addr  = vecs[i].e_addr;
        exp_color = vecs[i].e_color;
        chk($sformatf("vec%0d_latency", i), 32'(fk), 32'd6);
      end
      chk($sformatf("vec%0d_pulses", i), 32'(np), 32'(vecs[i].exp_n));
      chk($sformatf("vec%0d_addr", i),   32'(card_clicked_address), 32'(exp_addr));
      chk($sformatf("vec%0d_color", i),  32'(card_clicked_color), 32'(exp_color));
      release_btn();
      rearm();
    end

    // Gap click leaves the block armed: the next click works without re-enable.
    fill(2'b01, 12'h0C0);
    press_watch(12'd200, 12'd100, np, fk);
    chk("gap_pulses", 32'(np), 32'd0);
    release_btn();
    press_watch(12'd600, 12'd500, np, fk);
    chk("after_gap_pulses", 32'(np), 32'd1);
    chk("after_gap_addr",   32'(card_clicked_address), 32'd11);
    chk("after_gap_color",  32'(card_clicked_color), 32'h0CB);
    exp_addr  = 4'd11;
    exp_color = 12'h0CB;
    release_btn();

    // Disabled: clicks are ignored.
    wait_for_click_en = 1'b0;
    wait_neg(2);
    press_watch(12'd100, 12'd100, np, fk);
    chk("disabled_pulses", 32'(np), 32'd0);
    release_btn();

    // Enable dropped during LOOKUP.
    wait_for_click_en = 1'b1;
    wait_neg(3);
    fill(2'b01, 12'hE00);
    @(negedge clk);
    xpos = 12'd100;
    ypos = 12'd100;
    mouse_left = 1'b1;
    wait_neg(4);
    wait_for_click_en = 1'b0;
    watch_quiet(8, np);
    chk("abort_lookup_pulses", 32'(np), 32'd0);
    chk("abort_lookup_addr",   32'(card_clicked_address), 32'(exp_addr));
    chk("abort_lookup_color",  32'(card_clicked_color), 32'(exp_color));
    release_btn();

    // Enable dropped during CHECK: abort beats acceptance.
    wait_for_click_en = 1'b1;
    wait_neg(3);
    @(negedge clk);
    xpos = 12'd100;
    ypos = 12'd100;
    mouse_left = 1'b1;
    wait_neg(5);
    wait_for_click_en = 1'b0;
    watch_quiet(8, np);
    chk("abort_check_pulses", 32'(np), 32'd0);
    chk("abort_check_color",  32'(card_clicked_color), 32'(exp_color));
    release_btn();

    // Enable followed by a normal click.
    rearm();
    press_watch(12'd100, 12'd100, np, fk);
    chk("post_abort_pulses",  32'(np), 32'd1);
    chk("post_abort_latency", 32'(fk), 32'd6);
    chk("post_abort_color",   32'(card_clicked_color), 32'hE00);
    release_btn();

    // Button held while enable rises.
    wait_for_click_en = 1'b0;
    mouse_left = 1'b1;
    wait_neg(4);
    wait_for_click_en = 1'b1;
    watch_quiet(10, np);
    chk("held_en_pulses", 32'(np), 32'd0);
    release_btn();
    fill(2'b01, 12'hF00);
    press_watch(12'd100, 12'd100, np, fk);
    chk("held_release_pulses", 32'(np), 32'd1);
    chk("held_release_color",  32'(card_clicked_color), 32'hF00);
    watch_quiet(10, np);
    chk("hold_after_pulse", 32'(np), 32'd0);
    release_btn();

    // Reset asserted while in CHECK.
    rearm();
    fill(2'b01, 12'h0F0);
    @(negedge clk);
    xpos = 12'd600;
    ypos = 12'd500;
    mouse_left = 1'b1;
    wait_neg(5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_check_pressed", 32'(card_pressed), 32'd0);
    chk("rst_check_addr",    32'(card_clicked_address), 32'd0);
    chk("rst_check_color",   32'(card_clicked_color), 32'd0);
    chk("rst_check_rd_addr", 32'(card_rd_address), 32'd11 & 32'd0);
    rst = 1'b0;
    mouse_left = 1'b0;
    watch_quiet(6, np);
    chk("rst_check_no_pulse", 32'(np), 32'd0);

    // After reset the block starts in IDLE and accepts a fresh click.
    wait_neg(3);
    press_watch(12'd224, 12'd232, np, fk);
    chk("post_rst_pulses", 32'(np), 32'd1);
    chk("post_rst_addr",   32'(card_clicked_address), 32'd5);
    chk("post_rst_color",  32'(card_clicked_color), 32'h0F5);
    release_btn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
